// File: rtl/muldiv_ctrl_pkg.sv
// rtl/muldiv_ctrl_pkg.sv - shared encodings for the mult/div sequencer.
// The optional early-exit divide is selected with macro MULDIV_EARLY_EXIT_EN.
package muldiv_ctrl_pkg;

  localparam logic [1:0] MUL_U = 2'b00;
  localparam logic [1:0] MUL_S = 2'b01;
  localparam logic [1:0] DIV_U = 2'b10;
  localparam logic [1:0] DIV_S = 2'b11;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DIV  = 2'd2;

  function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? -v : v;
  endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// rtl/muldiv_ctrl_if.sv - EXE-stage request, MT write and HI/LO status bundle.
interface muldiv_ctrl_if;
  logic        start;
  logic [1:0]  alu2op;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        rhl_visit;
  logic        mt_we;
  logic        mt_sel;
  logic [31:0] mt_data;
  logic        flush;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, alu2op, op_a, op_b, rhl_visit, mt_we, mt_sel, mt_data, flush,
    input  busy, stall, hi, lo
  );

  modport slave (
    input  start, alu2op, op_a, op_b, rhl_visit, mt_we, mt_sel, mt_data, flush,
    output busy, stall, hi, lo
  );
endinterface

// File: rtl/muldiv_ctrl_div_iter.sv
// rtl/muldiv_ctrl_div_iter.sv - restoring radix-2 divider core on magnitudes.
// Macro MULDIV_EARLY_EXIT_EN enables the short path for |a| < |b| or b == 0.
import muldiv_ctrl_pkg::*;

module div_iter #(
  parameter int DIV_CYCLES = 33
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic        sgn,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [5:0]  cnt_init,
  output logic        done,
  output logic [31:0] q,
  output logic [31:0] r
);

  logic [31:0] mag_a, mag_b;
  logic [31:0] quo, rem, dvs, a_raw;
  logic        neg_q, neg_r, dvs_zero, early, early_q;
  logic [5:0]  iter;
  logic [32:0] rem_sh, diff;

  assign mag_a = mag32(a, sgn);
  assign mag_b = mag32(b, sgn);

`ifdef MULDIV_EARLY_EXIT_EN
  assign early = (mag_b == 32'd0) || (mag_a < mag_b);
`else
  assign early = 1'b0;
`endif

  assign cnt_init = early ? 6'd1 : 6'(DIV_CYCLES - 1);

  // Quotient bits shift in at the bottom of quo as dividend bits shift out the top.
  assign rem_sh = {rem, quo[31]};
  assign diff   = rem_sh - {1'b0, dvs};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      quo      <= '0;
      rem      <= '0;
      dvs      <= '0;
      a_raw    <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      dvs_zero <= 1'b0;
      early_q  <= 1'b0;
      iter     <= '0;
    end else if (load) begin
      quo      <= mag_a;
      rem      <= '0;
      dvs      <= mag_b;
      a_raw    <= a;
      neg_q    <= sgn & (a[31] ^ b[31]);
      neg_r    <= sgn & a[31];
      dvs_zero <= (b == 32'd0);
      early_q  <= early;
      iter     <= '0;
    end else if (step && iter != 6'd32) begin
      iter <= iter + 6'd1;
      if (!diff[32]) begin
        rem <= diff[31:0];
        quo <= {quo[30:0], 1'b1};
      end else begin
        rem <= rem_sh[31:0];
        quo <= {quo[30:0], 1'b0};
      end
    end
  end

  assign done = early_q | (iter == 6'd32);
  assign q = dvs_zero ? 32'hFFFF_FFFF : (early_q ? 32'd0 : (neg_q ? -quo : quo));
  assign r = (dvs_zero | early_q) ? a_raw : (neg_r ? -rem : rem);

endmodule

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - background MULT/DIV sequencer owning HI/LO with HI/LO-hazard stall.
// Macro MULDIV_EARLY_EXIT_EN shortens trivial divides (see div_iter).
import muldiv_ctrl_pkg::*;

module muldiv_ctrl #(
  parameter int MUL_CYCLES = 3,
  parameter int DIV_CYCLES = 33
) (
  input  logic clk,
  input  logic rst,
  muldiv_ctrl_if.slave bus
);

  logic [1:0]  state;
  logic [5:0]  cnt;
  logic [31:0] ma, mb, hi_q, lo_q, div_q, div_r;
  logic        msgn, is_mul_op, accept, div_done;
  logic        wr_mul, wr_div, wr_mt;
  logic [5:0]  div_cnt_init;
  logic signed [63:0] sa, sb, prod;

  assign is_mul_op = (bus.alu2op == MUL_U) || (bus.alu2op == MUL_S);
  assign accept    = (state == IDLE) && bus.start && !bus.flush;

  div_iter #(.DIV_CYCLES(DIV_CYCLES)) u_div (
    .clk      (clk),
    .rst      (rst),
    .load     (accept && !is_mul_op),
    .step     ((state == DIV) && (cnt != 6'd0)),
    .sgn      (bus.alu2op == DIV_S),
    .a        (bus.op_a),
    .b        (bus.op_b),
    .cnt_init (div_cnt_init),
    .done     (div_done),
    .q        (div_q),
    .r        (div_r)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      ma    <= '0;
      mb    <= '0;
      msgn  <= 1'b0;
    end else if (bus.flush) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          state <= is_mul_op ? MUL : DIV;
          cnt   <= is_mul_op ? 6'(MUL_CYCLES - 1) : div_cnt_init;
          ma    <= bus.op_a;
          mb    <= bus.op_b;
          msgn  <= (bus.alu2op == MUL_S);
        end
        MUL, DIV: begin
          if (cnt == 6'd0) state <= IDLE;
          else             cnt   <= cnt - 6'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign sa   = msgn ? {{32{ma[31]}}, ma} : {32'd0, ma};
  assign sb   = msgn ? {{32{mb[31]}}, mb} : {32'd0, mb};
  assign prod = sa * sb;

  assign wr_mul = (state == MUL) && (cnt == 6'd0) && !bus.flush;
  assign wr_div = (state == DIV) && (cnt == 6'd0) && div_done && !bus.flush;
  assign wr_mt  = (state == IDLE) && bus.mt_we && !bus.flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (wr_mul) begin
      hi_q <= prod[63:32];
      lo_q <= prod[31:0];
    end else if (wr_div) begin
      hi_q <= div_r;
      lo_q <= div_q;
    end else if (wr_mt) begin
      if (bus.mt_sel) hi_q <= bus.mt_data;
      else            lo_q <= bus.mt_data;
    end
  end

  assign bus.busy  = (state != IDLE);
  assign bus.stall = bus.busy & bus.rhl_visit & !bus.flush;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - scoreboard bench for muldiv_ctrl (honours MULDIV_EARLY_EXIT_EN).
module tb_muldiv_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  muldiv_ctrl_if m();
  muldiv_ctrl dut (.clk(clk), .rst(rst), .bus(m.slave));

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb2, q, r;
    logic [63:0] p;
    sa  = $signed(a);
    sb2 = $signed(b);
    case (op)
      2'b00: p = {32'd0, a} * {32'd0, b};
      2'b01: p = sa * sb2;
      2'b10: p = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      default: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb2;
          r = sa % sb2;
          p = {r[31:0], q[31:0]};
        end
      end
    endcase
    return p;
  endfunction

  function automatic int lat_of(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma, mb;
    if (!op[1]) return 3;
    ma = (op[0] && a[31]) ? 32'(0 - a) : a;
    mb = (op[0] && b[31]) ? 32'(0 - b) : b;
`ifdef MULDIV_EARLY_EXIT_EN
    if (b == 0 || ma < mb) return 2;
`else
    if (ma == mb + 1 && ma == 0) return 0;
`endif
    return 33;
  endfunction

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input bit visit);
    exp_t e;
    int n;
    sb.push_back('{tag, ehi, elo, lat_of(op, a, b)});
    @(negedge clk);
    m.start = 1'b1; m.alu2op = op; m.op_a = a; m.op_b = b;
    @(posedge clk);
    #1;
    m.start = 1'b0;
    m.rhl_visit = visit;
    n = 0;
    @(negedge clk);
    while (m.busy && n < 45) begin
      if (visit) check({tag, ".stall_busy"}, m.stall, 1);
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    e = sb.pop_front();
    check({e.tag, ".lat"}, n, e.lat);
    check({e.tag, ".hi"}, m.hi, e.hi);
    check({e.tag, ".lo"}, m.lo, e.lo);
    if (visit) check({tag, ".stall_done"}, m.stall, 0);
    m.rhl_visit = 1'b0;
  endtask

  task automatic mt(input logic sel, input logic [31:0] data, input logic fl);
    @(negedge clk);
    m.mt_we = 1'b1; m.mt_sel = sel; m.mt_data = data; m.flush = fl;
    @(posedge clk);
    #1;
    m.mt_we = 1'b0; m.flush = 1'b0;
  endtask

  initial begin
    logic [1:0]  op;
    logic [31:0] a, b;
    logic [63:0] p;
    m.start = 0; m.alu2op = 0; m.op_a = 0; m.op_b = 0; m.rhl_visit = 0;
    m.mt_we = 0; m.mt_sel = 0; m.mt_data = 0; m.flush = 0;

    repeat (2) @(posedge clk);
    #1;
    check("rst.busy", m.busy, 0);
    check("rst.stall", m.stall, 0);
    check("rst.hi", m.hi, 0);
    check("rst.lo", m.lo, 0);
    @(negedge clk) rst = 1'b1;

    mt(1'b1, 32'h1111_1111, 1'b0);
    check("mthi", m.hi, 32'h1111_1111);
    mt(1'b0, 32'h2222_2222, 1'b0);
    check("mtlo", m.lo, 32'h2222_2222);
    mt(1'b1, 32'hDEAD_BEEF, 1'b1);
    check("mt_flush.hi", m.hi, 32'h1111_1111);

    run_op("mult", 2'b01, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
    run_op("multu", 2'b00, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, 1'b0);
    run_op("divu_100_7", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1);
    run_op("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
    run_op("div_m7_2", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("div_5_0", 2'b11, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1);
    run_op("divu_3_9", 2'b10, 32'd3, 32'd9, 32'd3, 32'd0, 1'b0);
    run_op("div_7_m2", 2'b11, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0);

    for (int i = 0; i < 8; i++) begin
      op = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      if (i == 2) b = $urandom_range(0, 20);
      if (i == 3) a = $urandom_range(0, 50);
      p = model(op, a, b);
      run_op($sformatf("rand%0d", i), op, a, b, p[63:32], p[31:0], 1'b0);
    end

    // An in-flight divide killed by flush must leave HI/LO untouched.
    mt(1'b1, 32'h1111_1111, 1'b0);
    mt(1'b0, 32'h2222_2222, 1'b0);
    @(negedge clk);
    m.start = 1'b1; m.alu2op = 2'b10; m.op_a = 32'd1000; m.op_b = 32'd3;
    @(posedge clk);
    #1 m.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    m.flush = 1'b1; m.rhl_visit = 1'b1;
    @(negedge clk);
    check("flush.busy_during", m.busy, 1);
    check("flush.stall_masked", m.stall, 0);
    @(posedge clk);
    #1;
    m.flush = 1'b0; m.rhl_visit = 1'b0;
    check("flush.busy_after", m.busy, 0);
    repeat (30) @(posedge clk);
    #1;
    check("flush.hi", m.hi, 32'h1111_1111);
    check("flush.lo", m.lo, 32'h2222_2222);

    @(negedge clk);
    m.start = 1'b1; m.flush = 1'b1; m.alu2op = 2'b01; m.op_a = 32'd5; m.op_b = 32'd5;
    @(posedge clk);
    #1;
    m.start = 1'b0; m.flush = 1'b0;
    check("start_flush.busy", m.busy, 0);
    repeat (4) @(posedge clk);
    #1;
    check("start_flush.lo", m.lo, 32'h2222_2222);

    @(negedge clk);
    m.start = 1'b1; m.alu2op = 2'b01; m.op_a = 32'd7; m.op_b = 32'd9;
    @(posedge clk);
    #1;
    m.start = 1'b0; m.rhl_visit = 1'b1;
    @(posedge clk);
    #2;
    check("rst_mid.busy_before", m.busy, 1);
    rst = 1'b0;
    #1;
    check("rst_mid.busy", m.busy, 0);
    check("rst_mid.stall", m.stall, 0);
    check("rst_mid.hi", m.hi, 0);
    check("rst_mid.lo", m.lo, 0);
    @(negedge clk);
    rst = 1'b1; m.rhl_visit = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("rst_mid.no_resume", {m.hi, m.lo}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
